// File: rtl/jtpopeye_pkg.sv
// Shared types and constants for the Popeye ROM download path.
package jtpopeye_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_HOLD,
    ST_READY
  } dwnld_st_t;

  localparam logic [1:0] RGN_MAIN = 2'd0;
  localparam logic [1:0] RGN_CHAR = 2'd1;
  localparam logic [1:0] RGN_OBJ  = 2'd2;
  localparam logic [1:0] RGN_PROM = 2'd3;

  localparam logic [16:0] DEF_CHAR_START = 17'h08000;
  localparam logic [16:0] DEF_OBJ_START  = 17'h08800;
  localparam logic [16:0] DEF_PROM_START = 17'h10800;
  localparam logic [16:0] DEF_ROM_END    = 17'h10A40;

endpackage

// File: rtl/jtpopeye_dwnld_dec.sv
// Combinational ioctl address -> (region, local offset, out-of-range) decoder.
module jtpopeye_dwnld_dec
  import jtpopeye_pkg::*;
#(
  parameter logic [16:0] CHAR_START = DEF_CHAR_START,
  parameter logic [16:0] OBJ_START  = DEF_OBJ_START,
  parameter logic [16:0] PROM_START = DEF_PROM_START,
  parameter logic [16:0] ROM_END    = DEF_ROM_END
) (
  input  logic [21:0] addr,
  output logic [1:0]  rgn,
  output logic [14:0] offset,
  output logic        oor
);

  logic [16:0] base;

  always_comb begin
    rgn  = RGN_MAIN;
    base = '0;
    oor  = 1'b0;
    if (addr[21:17] != 5'd0) begin
      oor = 1'b1;
    end else if (addr[16:0] < CHAR_START) begin
      rgn  = RGN_MAIN;
      base = '0;
    end else if (addr[16:0] < OBJ_START) begin
      rgn  = RGN_CHAR;
      base = CHAR_START;
    end else if (addr[16:0] < PROM_START) begin
      rgn  = RGN_OBJ;
      base = OBJ_START;
    end else if (addr[16:0] < ROM_END) begin
      rgn  = RGN_PROM;
      base = PROM_START;
    end else begin
      oor = 1'b1;
    end
    offset = 15'(addr[16:0] - base);
  end

endmodule

// File: rtl/jtpopeye_dwnld.sv
// ROM download sequencer: ioctl byte stream -> per-region write strobes,
// byte count/checksum, and game reset held until the image has settled.
module jtpopeye_dwnld
  import jtpopeye_pkg::*;
#(
  parameter logic [16:0] CHAR_START = DEF_CHAR_START,
  parameter logic [16:0] OBJ_START  = DEF_OBJ_START,
  parameter logic [16:0] PROM_START = DEF_PROM_START,
  parameter logic [16:0] ROM_END    = DEF_ROM_END,
  parameter int          RST_HOLD   = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        downloading,
  input  logic [21:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_wr,
  output logic [7:0]  prog_data,
  output logic [14:0] prog_addr,
  output logic [3:0]  prog_we,
  output logic        game_rst,
  output logic        busy,
  output logic        err,
  output logic [16:0] byte_cnt,
  output logic [15:0] checksum
);

  localparam int HW = $clog2(RST_HOLD + 1);

  dwnld_st_t   state, nxt;
  logic        wr_last;
  logic        accept;
  logic [HW-1:0] hold_cnt;
  logic [1:0]  rgn;
  logic [14:0] offset;
  logic        oor;

  jtpopeye_dwnld_dec #(
    .CHAR_START (CHAR_START),
    .OBJ_START  (OBJ_START),
    .PROM_START (PROM_START),
    .ROM_END    (ROM_END)
  ) u_dec (
    .addr   (ioctl_addr),
    .rgn    (rgn),
    .offset (offset),
    .oor    (oor)
  );

  // Only a 0->1 transition of the write level counts, so a held wr is one byte.
  assign accept = (state == ST_LOAD) && ioctl_wr && !wr_last;

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:  if (downloading) nxt = ST_LOAD;
      ST_LOAD:  if (!downloading) nxt = ST_DRAIN;
      ST_DRAIN: nxt = ST_HOLD;
      ST_HOLD:  if (hold_cnt == HW'(RST_HOLD - 1)) nxt = ST_READY;
      ST_READY: if (downloading) nxt = ST_LOAD;
      default:  nxt = ST_IDLE;
    endcase
  end

  assign game_rst = (state != ST_READY);
  assign busy     = (state != ST_IDLE) && (state != ST_READY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      wr_last   <= 1'b0;
      hold_cnt  <= '0;
      prog_we   <= '0;
      prog_addr <= '0;
      prog_data <= '0;
      err       <= 1'b0;
      byte_cnt  <= '0;
      checksum  <= '0;
    end else begin
      state   <= nxt;
      wr_last <= ioctl_wr;
      prog_we <= '0;
      if (nxt == ST_LOAD && state != ST_LOAD) begin
        byte_cnt <= '0;
        checksum <= '0;
        err      <= 1'b0;
      end
      if (accept) begin
        if (oor) begin
          err <= 1'b1;
        end else begin
          prog_we   <= 4'b0001 << rgn;
          prog_addr <= offset;
          prog_data <= ioctl_data;
          byte_cnt  <= byte_cnt + 17'd1;
          checksum  <= checksum + {8'd0, ioctl_data};
        end
      end
      // Last byte has landed by the DRAIN cycle, so the length check goes here.
      if (state == ST_DRAIN) begin
        hold_cnt <= '0;
        if (byte_cnt != ROM_END) err <= 1'b1;
      end else if (state == ST_HOLD) begin
        hold_cnt <= hold_cnt + HW'(1);
      end
    end
  end

endmodule

// File: tb/tb_jtpopeye_dwnld.sv
// Scoreboard bench: stimulus pushes expected strobes, a negedge monitor pops them.
module tb_jtpopeye_dwnld;

  localparam logic [16:0] P_CHAR = 17'h01000;
  localparam logic [16:0] P_OBJ  = 17'h01100;
  localparam logic [16:0] P_PROM = 17'h02100;
  localparam logic [16:0] P_END  = 17'h02148;

  typedef struct packed {
    logic [3:0]  we;
    logic [14:0] addr;
    logic [7:0]  data;
  } strobe_t;

  logic        clk = 1'b0;
  logic        rst, downloading, ioctl_wr;
  logic [21:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic [7:0]  prog_data;
  logic [14:0] prog_addr;
  logic [3:0]  prog_we;
  logic        game_rst, busy, err;
  logic [16:0] byte_cnt;
  logic [15:0] checksum;

  always #5 clk = ~clk;

  jtpopeye_dwnld #(
    .CHAR_START (P_CHAR),
    .OBJ_START  (P_OBJ),
    .PROM_START (P_PROM),
    .ROM_END    (P_END),
    .RST_HOLD   (256)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .downloading (downloading),
    .ioctl_addr  (ioctl_addr),
    .ioctl_data  (ioctl_data),
    .ioctl_wr    (ioctl_wr),
    .prog_data   (prog_data),
    .prog_addr   (prog_addr),
    .prog_we     (prog_we),
    .game_rst    (game_rst),
    .busy        (busy),
    .err         (err),
    .byte_cnt    (byte_cnt),
    .checksum    (checksum)
  );

  strobe_t     sb[$];
  strobe_t     got, want;
  int          vectors = 0, miscompares = 0;
  int          rgn_cnt[4] = '{0, 0, 0, 0};
  logic [16:0] exp_cnt;
  logic [15:0] exp_sum;
  logic        exp_err;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
    end
  endtask

  function automatic strobe_t model(input logic [21:0] a, input logic [7:0] d);
    strobe_t s;
    s.data = d;
    s.we   = 4'b0000;
    s.addr = '0;
    if (a >= 22'(P_END))       s.we = 4'b0000;
    else if (a >= 22'(P_PROM)) begin s.we = 4'b1000; s.addr = 15'(a - 22'(P_PROM)); end
    else if (a >= 22'(P_OBJ))  begin s.we = 4'b0100; s.addr = 15'(a - 22'(P_OBJ)); end
    else if (a >= 22'(P_CHAR)) begin s.we = 4'b0010; s.addr = 15'(a - 22'(P_CHAR)); end
    else                       begin s.we = 4'b0001; s.addr = 15'(a); end
    return s;
  endfunction

  // One wr edge; 'last' drops downloading in the same cycle and returns one cycle later.
  task automatic send(input logic [21:0] a, input logic [7:0] d, input int hold, input bit last);
    strobe_t s;
    s = model(a, d);
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr   = 1'b1;
    if (last) downloading = 1'b0;
    if (s.we != 4'b0000) begin
      sb.push_back(s);
      exp_cnt++;
      exp_sum += {8'd0, d};
    end else begin
      exp_err = 1'b1;
    end
    repeat (hold) tick;
    ioctl_wr = 1'b0;
    if (!last) tick;
  endtask

  task automatic start_load(input string tag);
    downloading = 1'b1;
    tick;
    exp_cnt = '0;
    exp_sum = '0;
    exp_err = 1'b0;
    chk({tag, "_cnt_clear"}, byte_cnt, 0);
    chk({tag, "_err_clear"}, err, 0);
    chk({tag, "_busy"}, busy, 1);
  endtask

  // Entered in cycle T+1 where T is the first cycle with downloading low.
  task automatic release_chk(input string tag, input bit hold_err);
    chk({tag, "_drain_err"}, err, exp_err);
    tick;
    chk({tag, "_hold_err"}, err, hold_err);
    chk({tag, "_cnt"}, byte_cnt, exp_cnt);
    chk({tag, "_sum"}, checksum, exp_sum);
    repeat (255) tick;
    chk({tag, "_rst_t257"}, {game_rst, busy}, 2'b11);
    tick;
    chk({tag, "_rst_t258"}, {game_rst, busy}, 2'b00);
  endtask

  always @(negedge clk) begin
    if (prog_we !== 4'b0000) begin
      vectors++;
      got = {prog_we, prog_addr, prog_data};
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_strobe: got 0x%0h expected none", got);
      end else begin
        want = sb.pop_front();
        if (got !== want) begin
          miscompares++;
          $display("FAIL strobe: got 0x%0h expected 0x%0h", got, want);
        end
      end
      for (int k = 0; k < 4; k++) if (prog_we[k]) rgn_cnt[k]++;
    end
  end

  initial begin
    rst = 1'b1; downloading = 1'b0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_data = '0;
    exp_cnt = '0; exp_sum = '0; exp_err = 1'b0;
    tick; tick;
    chk("rst_outs", {prog_we, prog_addr, prog_data}, 0);
    chk("rst_flags", {game_rst, busy, err}, 3'b100);
    chk("rst_cnt", {byte_cnt, checksum}, 0);
    rst = 1'b0;
    tick;

    // Full image, data = addr[7:0]; final byte arrives as downloading falls.
    start_load("full");
    for (int a = 0; a < int'(P_END); a++)
      send(22'(a), 8'(a), 1, a == int'(P_END) - 1);
    release_chk("full", 1'b0);
    chk("full_main", rgn_cnt[0], 32'(P_CHAR));
    chk("full_char", rgn_cnt[1], 32'(P_OBJ - P_CHAR));
    chk("full_obj",  rgn_cnt[2], 32'(P_PROM - P_OBJ));
    chk("full_prom", rgn_cnt[3], 32'(P_END - P_PROM));

    // Boundaries, held wr, overflow and high-address drops.
    start_load("dir");
    send(22'h007FF, 8'hA5, 1, 1'b0);
    send(22'h00800, 8'h3C, 1, 1'b0);
    send(22'h010FF, 8'h11, 1, 1'b0);
    send(22'h00010, 8'h77, 5, 1'b0);
    chk("held_cnt", byte_cnt, 4);
    send(22'h02148, 8'h99, 1, 1'b0);
    chk("ovf_err", err, 1);
    chk("ovf_cnt", byte_cnt, 4);
    send(22'h100005, 8'h42, 1, 1'b0);
    chk("hiaddr_cnt", byte_cnt, 4);
    send(22'h02147, 8'hFE, 1, 1'b1);
    release_chk("dir", 1'b1);
    chk("dir_sum_hand", checksum, 16'h0267);
    chk("dir_cnt_hand", byte_cnt, 5);

    // Reset after 50 bytes, coinciding with a fresh edge, then a 100-byte short image.
    start_load("mid");
    for (int i = 0; i < 50; i++) send(22'(i), 8'(i * 3), 1, 1'b0);
    ioctl_addr = 22'h00040; ioctl_data = 8'hEE; ioctl_wr = 1'b1; rst = 1'b1;
    tick;
    chk("mid_rst_outs", {prog_we, prog_addr, prog_data}, 0);
    chk("mid_rst_flags", {game_rst, busy, err}, 3'b100);
    chk("mid_rst_cnt", {byte_cnt, checksum}, 0);
    rst = 1'b0; ioctl_wr = 1'b0;
    tick;
    exp_cnt = '0; exp_sum = '0; exp_err = 1'b0;
    chk("mid_reload_busy", busy, 1);
    for (int i = 0; i < 100; i++) send(22'h00100 + 22'(i), 8'(i + 7), 1, i == 99);
    release_chk("short", 1'b1);
    chk("short_cnt_hand", byte_cnt, 100);

    tick; tick;
    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/jtpopeye_dwnld.md
# jtpopeye_dwnld

ROM download sequencer between the MiSTer ioctl stream and the game's on-chip ROM/PROM memories. It decodes each downloaded byte into one of four regions: main CPU, characters, objects and colour PROMs. For each byte it issues a single-cycle write strobe with a region-local address, and counts bytes and computes a checksum. It also keeps the game in reset until the image has been fully written plus a settling interval. It sits between the framework's ioctl outputs and `jtpopeye_game`.

## Interface
Parameters:
- `CHAR_START`, 17'h08000: first byte of the character region. Main CPU region is 0 to CHAR_START-1.
- `OBJ_START`, 17'h08800: first byte of the object region.
- `PROM_START`, 17'h10800: first byte of the PROM region.
- `ROM_END`, 17'h10A40: total image length in bytes.
- `RST_HOLD`, 256: number of clock cycles `game_rst` stays high after the last write.

Ports:
- `clk` in 1: system clock, 40 MHz.
- `rst` in 1: synchronous, active-high reset.
- `downloading` in 1: high for the whole transfer.
- `ioctl_addr` in 22: byte address.
- `ioctl_data` in 8: byte data.
- `ioctl_wr` in 1: write request, level. It may stay high for more than one cycle.
- `prog_data` out 8: registered byte.
- `prog_addr` out 15: region-local address, registered.
- `prog_we` out 4: one-hot write strobe. Bit 0 main, bit 1 char, bit 2 obj, bit 3 PROM.
- `game_rst` out 1: reset request to the game.
- `busy` out 1: high in any state except IDLE and READY.
- `err` out 1: sticky image-error flag.
- `byte_cnt` out 17: number of bytes accepted.
- `checksum` out 16: modulo-2^16 sum of the accepted bytes.

## Operation
- States: IDLE, LOAD, DRAIN, HOLD, READY.
- IDLE → LOAD when `downloading` is 1. On entry to LOAD, clear `byte_cnt`, `checksum` and `err`.
- Write acceptance in LOAD: a rising edge of `ioctl_wr` (current 1, previous 0) accepts the byte.
  - A level held high is accepted only once.
  - A new edge can only occur after a low cycle, so no buffering beyond one stage is needed.
- Region decode of an accepted address `a` (bits 21:17 must be zero):
  - `a < CHAR_START` → main, local address `a`.
  - `a < OBJ_START` → char, local address `a - CHAR_START`.
  - `a < PROM_START` → obj, local address `a - OBJ_START`.
  - `a < ROM_END` → PROM, local address `a - PROM_START`.
  - Otherwise, or if any of bits 21:17 is set, the byte is dropped: no strobe, `err` is set, count and checksum are unchanged.
- For an in-range byte: `byte_cnt` += 1; `checksum` += zero-extended data, wrapping.
- LOAD → DRAIN when `downloading` falls. An edge that arrives in the same cycle `downloading` falls is still accepted.
- DRAIN → HOLD after one cycle, which lets the last strobe retire.
  - On entry to HOLD, set `err` if `byte_cnt` != `ROM_END` (short or padded image).
- HOLD counts `RST_HOLD` cycles, then → READY.
- READY → LOAD (with counters cleared) if `downloading` rises again.
- `game_rst` is 1 in reset, IDLE, LOAD, DRAIN and HOLD. It is 0 only in READY.

## Timing
- Reset values:
  - state IDLE
  - `prog_we` = 0
  - `prog_addr` = 0
  - `prog_data` = 0
  - `game_rst` = 1
  - `busy` = 0
  - `err` = 0
  - `byte_cnt` = 0
  - `checksum` = 0
- Latency: for a rising edge seen in cycle N, `prog_we`, `prog_addr` and `prog_data` are valid in cycle N+1. `prog_we` is high for exactly one cycle.
- `byte_cnt`, `checksum` and `err` update in cycle N+1.
- `game_rst` falls exactly `RST_HOLD`+2 cycles after the first cycle with `downloading` low. The +2 covers the DRAIN cycle and the HOLD entry cycle.
- `rst` in the middle of a transfer:
  - All state returns to reset values immediately, in the same cycle.
  - A strobe that was pending is cancelled.
  - If `downloading` is still high, the block re-enters LOAD on the next cycle and accepts later bytes normally.
- `ioctl_wr` outside LOAD is ignored.

## Structure
- Shared package `jtpopeye_pkg`:
  - state enum `dwnld_st_t`.
  - region index constants `RGN_MAIN=0`, `RGN_CHAR=1`, `RGN_OBJ=2`, `RGN_PROM=3`.
  - the default region boundaries.
- Sub-module `jtpopeye_dwnld_dec`: combinational address-to-region/offset decoder, including the out-of-range flag, so it can be tested separately.
- The top level holds the FSM, edge detector, output register, counters and hold timer.

## Test plan
- Full image, 0x10A40 bytes with data = addr[7:0], one wr pulse every 8 cycles:
  - exactly 0x8000 main, 0x800 char, 0x8000 obj and 0x240 PROM strobes;
  - `byte_cnt`=0x10A40, `err`=0;
  - `checksum` equal to the model sum.
- Boundaries: addresses 0x07FF, 0x0800 and 0x10A3F are routed correctly:
  - 0x07FF: main strobe, local 0x7FF.
  - 0x0800: main strobe, local 0x800.
  - 0x10A3F: PROM strobe, local 0x23F.
  - 0x087FF: char strobe, local 0x7FF.
- Held wr: `ioctl_wr` high for 5 cycles produces a single strobe, and `byte_cnt` increments by 1.
- Overflow and short image:
  - A byte at 0x10A40 gives no strobe and sets `err`.
  - A separate image of 100 bytes gives `err`=1 on entry to HOLD, with `byte_cnt`=100.
- Release timing: `downloading` falls at cycle T.
  - `game_rst` falls at T+258 (RST_HOLD=256); `busy` falls at the same cycle.
  - Edge at T-0 accepted.
- Reset mid-load: assert `rst` for 1 cycle after 50 bytes.
  - Outputs return to reset values, `game_rst`=1.
  - Subsequent bytes are counted from 0.
